// File: rtl/hist_peak_engine.sv
// Batch TDC depth histogram: bins accepted beats over batch_num frames, then scans for the peak bin.
// Define HIST_PEAK2_EN to also report the second-highest bin (out_bin2/out_cnt2).
module hist_peak_engine #(
  parameter int DW        = 15,
  parameter int NBINS     = 64,
  parameter int BIN_SHIFT = 9,
  parameter int CW        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [3:0]               int_th,
  input  logic [CW-1:0]            cnt_th,
  input  logic [15:0]              batch_num,
  input  logic [DW-1:0]            in_data,
  input  logic [3:0]               in_int,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(NBINS)-1:0] out_bin,
  output logic [CW-1:0]            out_cnt,
  output logic                     out_hit,
`ifdef HIST_PEAK2_EN
  output logic [$clog2(NBINS)-1:0] out_bin2,
  output logic [CW-1:0]            out_cnt2,
`endif
  output logic                     out_valid,
  input  logic                     out_ready
);

  // state   | meaning
  // S_IDLE  | waiting for en, batch_num latched on exit
  // S_ACCUM | accepting beats, counting frames
  // S_SCAN  | one bin per cycle, tracking running max
  // S_OUT   | result held until out_ready
  // S_CLEAR | zero bins and frame counter

  localparam int BW = $clog2(NBINS);
  localparam logic [BW-1:0] LAST_IDX = BW'(NBINS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCAN, S_OUT, S_CLEAR} state_t;

  state_t        state_q;
  logic [CW-1:0] bins_q [NBINS];
  logic [15:0]   frame_q, batch_q;
  logic [BW-1:0] idx_q, inc_bin_q, in_bin;
  logic          inc_vld_q;
  logic [BW-1:0] max_bin_q, max_bin_d;
  logic [CW-1:0] max_cnt_q, max_cnt_d, scan_val;
  logic          in_ready_q, out_valid_q, out_hit_q;
  logic [BW-1:0] out_bin_q;
  logic [CW-1:0] out_cnt_q;
  logic          accept, frame_done;
  logic [16:0]   frame_inc;
`ifdef HIST_PEAK2_EN
  logic [BW-1:0] sec_bin_q, sec_bin_d, out_bin2_q;
  logic [CW-1:0] sec_cnt_q, sec_cnt_d, out_cnt2_q;
  logic          sec_vld_q, sec_vld_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign in_bin     = BW'(in_data >> BIN_SHIFT);
  assign accept     = in_valid & in_ready_q;
  assign frame_inc  = {1'b0, frame_q} + 17'd1;
  assign frame_done = accept & in_last & (frame_inc == {1'b0, batch_q});

  // The final beat's increment lands in the first SCAN cycle, so forward it.
  always_comb begin
    scan_val = bins_q[idx_q];
    if (inc_vld_q && (inc_bin_q == idx_q)) scan_val = sat_inc(bins_q[idx_q]);
    max_cnt_d = max_cnt_q;
    max_bin_d = max_bin_q;
`ifdef HIST_PEAK2_EN
    sec_cnt_d = sec_cnt_q;
    sec_bin_d = sec_bin_q;
    sec_vld_d = sec_vld_q;
`endif
    if (idx_q == '0) begin
      max_cnt_d = scan_val;
      max_bin_d = idx_q;
`ifdef HIST_PEAK2_EN
      sec_vld_d = 1'b0;
`endif
    end else if (scan_val > max_cnt_q) begin
      max_cnt_d = scan_val;
      max_bin_d = idx_q;
`ifdef HIST_PEAK2_EN
      sec_cnt_d = max_cnt_q;
      sec_bin_d = max_bin_q;
      sec_vld_d = 1'b1;
    end else if (!sec_vld_q || (scan_val > sec_cnt_q)) begin
      sec_cnt_d = scan_val;
      sec_bin_d = idx_q;
      sec_vld_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
      frame_q     <= '0;
      batch_q     <= 16'd1;
      idx_q       <= '0;
      inc_vld_q   <= 1'b0;
      inc_bin_q   <= '0;
      max_bin_q   <= '0;
      max_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_cnt_q   <= '0;
      out_hit_q   <= 1'b0;
`ifdef HIST_PEAK2_EN
      sec_bin_q   <= '0;
      sec_cnt_q   <= '0;
      sec_vld_q   <= 1'b0;
      out_bin2_q  <= '0;
      out_cnt2_q  <= '0;
`endif
    end else begin
      inc_vld_q <= accept && (in_int >= int_th);
      inc_bin_q <= in_bin;
      if (inc_vld_q) bins_q[inc_bin_q] <= sat_inc(bins_q[inc_bin_q]);
      case (state_q)
        S_IDLE: begin
          if (en) begin
            batch_q    <= (batch_num == 16'd0) ? 16'd1 : batch_num;
            in_ready_q <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept && in_last) frame_q <= frame_inc[15:0];
          if (frame_done) begin
            in_ready_q <= 1'b0;
            idx_q      <= '0;
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          max_cnt_q <= max_cnt_d;
          max_bin_q <= max_bin_d;
`ifdef HIST_PEAK2_EN
          sec_cnt_q <= sec_cnt_d;
          sec_bin_q <= sec_bin_d;
          sec_vld_q <= sec_vld_d;
`endif
          idx_q <= idx_q + BW'(1);
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            out_bin_q   <= max_bin_d;
            out_cnt_q   <= max_cnt_d;
            out_hit_q   <= (max_cnt_d >= cnt_th);
`ifdef HIST_PEAK2_EN
            out_bin2_q  <= sec_bin_d;
            out_cnt2_q  <= sec_cnt_d;
`endif
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
          frame_q   <= '0;
          max_cnt_q <= '0;
          max_bin_q <= '0;
          if (en) begin
            in_ready_q <= 1'b1;
            state_q    <= S_ACCUM;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_cnt   = out_cnt_q;
  assign out_hit   = out_hit_q;
`ifdef HIST_PEAK2_EN
  assign out_bin2  = out_bin2_q;
  assign out_cnt2  = out_cnt2_q;
`endif

endmodule

// File: tb/tb_hist_peak_engine.sv
// Scoreboard bench for hist_peak_engine: directed scenarios plus random batches
// checked against an array-based histogram model.
module tb_hist_peak_engine;

  localparam int DW = 15, NBINS = 64, BIN_SHIFT = 9, CW = 8;
  localparam int BW = $clog2(NBINS);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0]    int_th = '0;
  logic [CW-1:0] cnt_th = '0;
  logic [15:0]   batch_num = '0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_int = '0;
  logic          in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [BW-1:0] out_bin;
  logic [CW-1:0] out_cnt;
  logic          out_hit, out_valid, out_ready = 1'b0;
`ifdef HIST_PEAK2_EN
  logic [BW-1:0] out_bin2;
  logic [CW-1:0] out_cnt2;
`endif

  hist_peak_engine #(.DW(DW), .NBINS(NBINS), .BIN_SHIFT(BIN_SHIFT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .int_th(int_th), .cnt_th(cnt_th),
    .batch_num(batch_num), .in_data(in_data), .in_int(in_int), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_bin(out_bin), .out_cnt(out_cnt),
    .out_hit(out_hit),
`ifdef HIST_PEAK2_EN
    .out_bin2(out_bin2), .out_cnt2(out_cnt2),
`endif
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef struct { int bin; int cnt; int hit; int bin2; int cnt2; } exp_t;
  exp_t sb[$];
  int   hist[NBINS];
  int   n_cmp = 0, n_err = 0;
  int   cur_ith = 0, cur_cth = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: peak is the first index holding the maximum count; second peak
  // is the same search with the peak index excluded.
  function automatic exp_t model_result();
    exp_t e;
    int b1 = 0, b2 = -1;
    for (int i = 1; i < NBINS; i++) if (hist[i] > hist[b1]) b1 = i;
    for (int i = 0; i < NBINS; i++)
      if (i != b1 && (b2 < 0 || hist[i] > hist[b2])) b2 = i;
    e.bin = b1; e.cnt = hist[b1]; e.hit = (hist[b1] >= cur_cth) ? 1 : 0;
    e.bin2 = b2; e.cnt2 = hist[b2];
    return e;
  endfunction

  function automatic int mk_data(input int bin);
    return (bin << BIN_SHIFT) | int'($urandom_range(0, (1 << BIN_SHIFT) - 1));
  endfunction

  task automatic start_batch(input int bn, input int ith, input int cth);
    batch_num = 16'(bn); int_th = 4'(ith); cnt_th = CW'(cth);
    cur_ith = ith; cur_cth = cth;
    foreach (hist[i]) hist[i] = 0;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("in_ready_start", int'(in_ready), 1);
  endtask

  task automatic send_beat(input int data, input int inten, input bit last, input bit gap);
    if (gap) tick();
    in_valid = 1'b1; in_data = DW'(data); in_int = 4'(inten); in_last = last;
    if (!in_ready) begin
      check("beat_ready", int'(in_ready), 1);
    end else begin
      tick();
      if (inten >= cur_ith && hist[(data >> BIN_SHIFT) % NBINS] < CMAX)
        hist[(data >> BIN_SHIFT) % NBINS]++;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_batch(input int stall, input bit hold_en);
    int k;
    check("in_ready_drop", int'(in_ready), 0);
    sb.push_back(model_result());
    out_ready = 1'b0;
    if (hold_en) en = 1'b1;
    for (k = 0; k < NBINS + 20; k++) begin
      if (out_valid) break;
      tick();
    end
    check("out_valid_rise", int'(out_valid), 1);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      if (sb.size() > 0) begin
        check("stall_bin", int'(out_bin), sb[0].bin);
        check("stall_cnt", int'(out_cnt), sb[0].cnt);
      end
      tick();
    end
    for (k = 0; k < 200; k++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (sb.size() == 0) break;
    end
    out_ready = 1'b0;
    if (sb.size() != 0) begin
      check("handshake_timeout", sb.size(), 0);
      sb.delete();
    end
    check("out_valid_drop", int'(out_valid), 0);
    tick(); tick();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got out_bin=%0d out_cnt=%0d expected no beat", out_bin, out_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_bin", int'(out_bin), e.bin);
        check("out_cnt", int'(out_cnt), e.cnt);
        check("out_hit", int'(out_hit), e.hit);
`ifdef HIST_PEAK2_EN
        check("out_bin2", int'(out_bin2), e.bin2);
        check("out_cnt2", int'(out_cnt2), e.cnt2);
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_out_hit", int'(out_hit), 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", int'(in_ready), 0);

    // Ten single-beat frames at bin 10, intensity above and below threshold.
    start_batch(10, 5, 5);
    for (int f = 0; f < 10; f++) send_beat(32'h1400, 6, 1'b1, 1'b0);
    finish_batch(0, 1'b0);
    start_batch(10, 5, 5);
    for (int f = 0; f < 10; f++) send_beat(32'h1400, 4, 1'b1, f % 3 == 0);
    finish_batch(0, 1'b0);

    // Saturation: 300 back-to-back beats into bin 3 in one frame.
    start_batch(1, 0, 0);
    for (int i = 0; i < 300; i++) send_beat(mk_data(3), 15, i == 299, 1'b0);
    finish_batch(0, 1'b0);

    // Tie between bins 7 and 2 at count 4; bin 5 lower.
    start_batch(1, 0, 4);
    for (int i = 0; i < 10; i++)
      send_beat(mk_data(i >= 8 ? 5 : (i % 2 == 0 ? 7 : 2)), 9, i == 9, 1'b0);
    finish_batch(0, 1'b0);

    // Backpressure for 20 cycles with en held, then next batch must start empty.
    start_batch(1, 0, 2);
    for (int i = 0; i < 6; i++) send_beat(mk_data($urandom_range(0, 3)), 15, i == 5, 1'b0);
    finish_batch(20, 1'b1);
    en = 1'b0;
    check("auto_restart_ready", int'(in_ready), 1);
    cur_ith = 0; cur_cth = 2;
    foreach (hist[i]) hist[i] = 0;
    send_beat(mk_data(5), 15, 1'b1, 1'b0);
    finish_batch(0, 1'b0);

    // Reset mid-SCAN discards the batch.
    start_batch(1, 0, 1);
    send_beat(mk_data(9), 15, 1'b1, 1'b0);
    check("in_ready_drop", int'(in_ready), 0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < NBINS + 10; k++) begin
      if (out_valid || in_ready) seen++;
      tick();
    end
    out_ready = 1'b0;
    check("rst_scan_no_output", seen, 0);

    // Random batches.
    for (int b = 0; b < 10; b++) begin
      int bn, nfr, nb, span;
      bn = $urandom_range(0, 3);
      nfr = (bn == 0) ? 1 : bn;
      span = (b % 2 == 0) ? 4 : NBINS - 1;
      start_batch(bn, $urandom_range(0, 12), $urandom_range(0, 6));
      for (int f = 0; f < nfr; f++) begin
        nb = $urandom_range(1, 8);
        for (int i = 0; i < nb; i++)
          send_beat(mk_data($urandom_range(0, span)), $urandom_range(0, 15),
                    (i == nb - 1), ($urandom_range(0, 3) == 0));
      end
      finish_batch($urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hist_peak_engine.md
HIST_PEAK_ENGINE -- requirements
Module: hist_peak_engine

Interface
REQ-001 SHALL have parameter DW, default 15, TDC depth-code width.
REQ-002 SHALL have parameter NBINS, default 64, bin count (power of 2, 8..256).
REQ-003 SHALL have parameter BIN_SHIFT, default 9; bin index = in_data >> BIN_SHIFT, truncated to log2(NBINS) bits.
REQ-004 SHALL have parameter CW, default 8, bin counter width.
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-006 clk  input  1  logic clock, all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  start accumulation; sampled only in IDLE.
REQ-009 int_th  input  4  minimum intensity for a sample to be binned.
REQ-010 cnt_th  input  CW  minimum peak count for out_hit.
REQ-011 batch_num  input  16  frames per histogram; latched on IDLE->ACCUM; 0 treated as 1.
REQ-012 in_data / in_int / in_last  input  DW / 4 / 1  TDC depth code, intensity, last beat of frame.
REQ-013 in_valid  input  1 ; in_ready  output  1  input handshake.
REQ-014 out_bin  output  log2(NBINS)  peak bin; out_cnt  output  CW  peak count; out_hit  output  1  out_cnt >= cnt_th.
REQ-015 out_valid  output  1 ; out_ready  input  1  output handshake.

Function
REQ-016 SHALL implement states IDLE, ACCUM, SCAN, OUT, CLEAR.
REQ-017 IDLE->ACCUM when en=1; in_ready=1 only in ACCUM.
REQ-018 Accepted beat (in_valid & in_ready) with in_int >= int_th SHALL increment its bin the next cycle; back-to-back same-bin beats SHALL each count.
REQ-019 Bin counters SHALL saturate at 2^CW-1.
REQ-020 Every accepted beat with in_last=1 SHALL count a frame, even if intensity-rejected.
REQ-021 On the cycle the batch_num-th frame's last beat is accepted, in_ready SHALL drop next cycle and ACCUM->SCAN.
REQ-022 SCAN SHALL examine one bin per cycle, index 0..NBINS-1 (NBINS cycles); a bin replaces the running max only if strictly greater (ties: lowest index).
REQ-023 All-zero histogram SHALL report out_bin=0, out_cnt=0.
REQ-024 SCAN->OUT: out_valid=1, outputs stable until out_valid & out_ready.
REQ-025 OUT->CLEAR on handshake; CLEAR zeroes all bins and frame counter in one cycle, then ACCUM if en=1 else IDLE.
REQ-026 en deasserted in ACCUM/SCAN/OUT SHALL NOT abort the current batch.

Reset
REQ-027 rst SHALL force IDLE, clear all bins, frame counter, running max, and drive in_ready=0, out_valid=0, out_bin=0, out_cnt=0, out_hit=0.
REQ-028 rst in any state, including mid-SCAN or OUT, SHALL discard the batch with no output beat.

Configuration
REQ-029 Macro HIST_PEAK2_EN SHALL, when defined, add outputs out_bin2 (log2(NBINS)) and out_cnt2 (CW): highest bin excluding the peak bin, same tie rule, valid with out_valid.
REQ-030 Without HIST_PEAK2_EN the ports and second-peak logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, en=1, batch_num=10, int_th=5, cnt_th=5, 10 frames of 1 beat in_data=0x1400 in_int=6 -> one beat out_bin=10, out_cnt=10, out_hit=1.
REQ-032 Same stimulus, in_int=4 -> out_cnt=0, out_bin=0, out_hit=0 after 10 frames.
REQ-033 CW=8, 300 beats bin 3 in one frame, batch_num=1 -> out_cnt=255, out_bin=3.
REQ-034 Bins 7 and 2 both reach count 4 -> out_bin=2; with HIST_PEAK2_EN out_bin2=7, out_cnt2=4.
REQ-035 out_ready held 0 for 20 cycles -> out_valid held, outputs stable, in_ready=0; after handshake first beat of next batch bins from zero.
REQ-036 rst pulsed mid-SCAN -> no out_valid, IDLE, next batch result unaffected.
